// File: rtl/femto_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : femto_bus_pkg
// Description : Shared types and constants for the femto bus decoder:
//               FSM state encoding, default slave map, unmapped read value.
// Revision    : 1.0 - initial release
// ============================================================================
package femto_bus_pkg;

    // Widest slave index supported (up to 8 slaves)
    localparam int c_max_slaves = 8;
    localparam int c_sel_w      = 3;

    // Access FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    // Default 4-slave map, slave 0 in the LSBs
    localparam logic [127:0] c_def_base_addrs = {
        32'h0042_0000, 32'h0040_0000, 32'h0001_0000, 32'h0000_0000
    };
    localparam logic [127:0] c_def_addr_masks = {
        32'hFFFF_FFE0, 32'hFFFF_FFE0, 32'hFFFF_0000, 32'hFFFF_FC00
    };

    // Value returned for unmapped, aborted or idle reads
    localparam logic [31:0] c_unmapped_rdata = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/femto_bus_decoder_addr_match.sv
`default_nettype none
// ============================================================================
// Module      : femto_addr_match
// Description : Compares the CPU address against every slave base/mask pair
//               and priority-encodes the result (lowest index wins).
// Revision    : 1.0 - initial release
// ============================================================================
module femto_addr_match
    import femto_bus_pkg::*;
#(
    parameter int                     NSLAVES    = 4,
    parameter logic [32*NSLAVES-1:0]  BASE_ADDRS = c_def_base_addrs,
    parameter logic [32*NSLAVES-1:0]  ADDR_MASKS = c_def_addr_masks
) (
    input  logic [31:0]         addr,
    output logic                hit,
    output logic [c_sel_w-1:0]  idx
);

    // Scan from the highest slave down so the lowest matching index is the last one written
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if ((addr & ADDR_MASKS[32*i +: 32]) == BASE_ADDRS[32*i +: 32]) begin
                hit = 1'b1;
                idx = c_sel_w'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/femto_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module      : femto_bus_decoder
// Description : Decodes femtorv-style CPU memory requests onto NSLAVES slave
//               channels, holds the CPU while the selected slave is busy and
//               records the first unmapped/aborted access.
//               Optional macro FEMTO_BUS_TIMEOUT_EN adds a wait-state
//               watchdog that aborts after TIMEOUT_CYCLES busy cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module femto_bus_decoder
    import femto_bus_pkg::*;
#(
    parameter int                     NSLAVES        = 4,
    parameter logic [32*NSLAVES-1:0]  BASE_ADDRS     = c_def_base_addrs,
    parameter logic [32*NSLAVES-1:0]  ADDR_MASKS     = c_def_addr_masks,
    parameter int                     TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             mem_addr,
    input  logic                    mem_rstrb,
    input  logic [3:0]              mem_wmask,
    output logic [31:0]             mem_rdata,
    output logic                    mem_rbusy,
    output logic                    mem_wbusy,
    output logic [NSLAVES-1:0]      s_rd,
    output logic [NSLAVES-1:0]      s_wr,
    input  logic [32*NSLAVES-1:0]   s_rdata,
    input  logic [NSLAVES-1:0]      s_rbusy,
    input  logic [NSLAVES-1:0]      s_wbusy,
    input  logic                    err_clr,
    output logic                    err_flag,
    output logic [31:0]             err_addr
);

    // Elaboration-time parameter range checks
    if (NSLAVES < 1 || NSLAVES > c_max_slaves) begin : g_bad_nslaves
        $error("femto_bus_decoder: NSLAVES out of range 1..8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("femto_bus_decoder: TIMEOUT_CYCLES out of range 1..65535");
    end

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_sel_w-1:0]     r_sel;
    logic                   r_err_flag;
    logic [31:0]            r_err_addr;

    logic                   w_hit;
    logic [c_sel_w-1:0]     w_idx;
    logic                   w_wr_req;
    logic                   w_rd_req;
    logic                   w_accept;
    logic                   w_issue;
    logic                   w_tmo;
    logic                   w_err_set;
    logic [31:0]            w_err_addr;
    logic [7:0]             w_rbusy_x;
    logic [7:0]             w_wbusy_x;
    logic [31:0]            w_rdata_arr [c_max_slaves];
    logic                   w_rbusy_sel;
    logic                   w_wbusy_sel;

    femto_addr_match #(
        .NSLAVES    (NSLAVES),
        .BASE_ADDRS (BASE_ADDRS),
        .ADDR_MASKS (ADDR_MASKS)
    ) u_match (
        .addr (mem_addr),
        .hit  (w_hit),
        .idx  (w_idx)
    );

    // A write wins over a coincident read strobe
    assign w_wr_req = |mem_wmask;
    assign w_rd_req = mem_rstrb & ~w_wr_req;

    // Widen per-slave inputs to the full 8-entry space so a 3-bit select always indexes in range
    always_comb begin
        w_rbusy_x = '0;
        w_wbusy_x = '0;
        w_rbusy_x[NSLAVES-1:0] = s_rbusy;
        w_wbusy_x[NSLAVES-1:0] = s_wbusy;
        for (int i = 0; i < c_max_slaves; i++) begin
            w_rdata_arr[i] = '0;
        end
        for (int i = 0; i < NSLAVES; i++) begin
            w_rdata_arr[i] = s_rdata[32*i +: 32];
        end
    end

    assign w_rbusy_sel = w_rbusy_x[r_sel];
    assign w_wbusy_sel = w_wbusy_x[r_sel];

`ifdef FEMTO_BUS_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;
    logic [31:0] r_acc_addr;
    logic        w_wait_busy;

    assign w_wait_busy = ((r_state == RD_WAIT) && w_rbusy_sel) ||
                         ((r_state == WR_WAIT) && w_wbusy_sel);
    assign w_tmo       = w_wait_busy && (r_tmo_cnt == 16'(TIMEOUT_CYCLES));
    assign w_err_addr  = w_tmo ? r_acc_addr : mem_addr;

    // Count busy wait cycles since the last accept; remember the accepted address for abort reporting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt  <= '0;
            r_acc_addr <= '0;
        end else if (w_accept) begin
            r_tmo_cnt  <= '0;
            r_acc_addr <= mem_addr;
        end else if (w_wait_busy) begin
            r_tmo_cnt  <= r_tmo_cnt + 16'd1;
        end
    end
`else
    assign w_tmo      = 1'b0;
    assign w_err_addr = mem_addr;
`endif

    // Next state: accept in IDLE or when the pending slave stops stalling; abort on watchdog expiry
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE:    w_accept = 1'b1;
            RD_WAIT: begin
                if (w_tmo)             w_state_nxt = IDLE;
                else if (!w_rbusy_sel) w_accept    = 1'b1;
            end
            WR_WAIT: begin
                if (w_tmo)             w_state_nxt = IDLE;
                else if (!w_wbusy_sel) w_accept    = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_accept) begin
            if (w_hit && w_wr_req)      w_state_nxt = WR_WAIT;
            else if (w_hit && w_rd_req) w_state_nxt = RD_WAIT;
            else                        w_state_nxt = IDLE;
        end
    end

    // State and selected-slave registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept && w_hit && (w_wr_req || w_rd_req)) r_sel <= w_idx;
        end
    end

    // Slave strobes are combinational in the accept cycle and suppressed while reset is held
    assign w_issue = w_accept & w_hit & ~reset;
    assign s_rd    = NSLAVES'(w_issue & w_rd_req) << w_idx;
    assign s_wr    = NSLAVES'(w_issue & w_wr_req) << w_idx;

    assign mem_rdata = ((r_state == RD_WAIT) && !w_tmo) ? w_rdata_arr[r_sel] : c_unmapped_rdata;
    assign mem_rbusy = (r_state == RD_WAIT) && w_rbusy_sel && !w_tmo;
    assign mem_wbusy = (r_state == WR_WAIT) && w_wbusy_sel && !w_tmo;

    assign w_err_set = (w_accept && (w_wr_req || w_rd_req) && !w_hit) || w_tmo;

    // Sticky error: first address is kept until cleared; a set coinciding with clear records the new one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_flag <= 1'b0;
            r_err_addr <= '0;
        end else if (w_err_set) begin
            r_err_flag <= 1'b1;
            if (!r_err_flag || err_clr) r_err_addr <= w_err_addr;
        end else if (err_clr) begin
            r_err_flag <= 1'b0;
            r_err_addr <= '0;
        end
    end

    assign err_flag = r_err_flag;
    assign err_addr = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_femto_bus_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_femto_bus_decoder
// Description : Directed self-checking bench for femto_bus_decoder with the
//               default slave map and TIMEOUT_CYCLES = 8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_femto_bus_decoder;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  mem_addr;
    logic         mem_rstrb;
    logic [3:0]   mem_wmask;
    logic [31:0]  mem_rdata;
    logic         mem_rbusy;
    logic         mem_wbusy;
    logic [3:0]   s_rd;
    logic [3:0]   s_wr;
    logic [127:0] s_rdata;
    logic [3:0]   s_rbusy;
    logic [3:0]   s_wbusy;
    logic         err_clr;
    logic         err_flag;
    logic [31:0]  err_addr;

    int n_checks = 0;
    int n_err    = 0;
    int busy_cnt;
    int exp_busy;

    femto_bus_decoder #(
        .NSLAVES        (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_addr  (mem_addr),
        .mem_rstrb (mem_rstrb),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata),
        .mem_rbusy (mem_rbusy),
        .mem_wbusy (mem_wbusy),
        .s_rd      (s_rd),
        .s_wr      (s_wr),
        .s_rdata   (s_rdata),
        .s_rbusy   (s_rbusy),
        .s_wbusy   (s_wbusy),
        .err_clr   (err_clr),
        .err_flag  (err_flag),
        .err_addr  (err_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs are sampled on the falling edge
    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        mem_addr  = '0;
        mem_rstrb = 1'b0;
        mem_wmask = 4'h0;
        s_rdata   = {32'h0, 32'h0, 32'hCAFE_F00D, 32'h1234_5678};
        s_rbusy   = 4'h0;
        s_wbusy   = 4'h0;
        err_clr   = 1'b0;

        // Reset state
        #2;
        chk("rst_s_rd",     32'(s_rd), 32'h0);
        chk("rst_rbusy",    32'(mem_rbusy), 32'h0);
        chk("rst_rdata",    mem_rdata, 32'h0);
        chk("rst_err_flag", 32'(err_flag), 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // Simple read of slave 0, no busy
        mem_addr = 32'h0000_0010; mem_rstrb = 1'b1;
        mid();
        chk("rd0_s_rd", 32'(s_rd), 32'h1);
        chk("rd0_s_wr", 32'(s_wr), 32'h0);
        tick();
        mem_rstrb = 1'b0;
        mid();
        chk("rd0_s_rd_off", 32'(s_rd), 32'h0);
        chk("rd0_rdata",    mem_rdata, 32'h1234_5678);
        chk("rd0_rbusy",    32'(mem_rbusy), 32'h0);
        tick();
        mid();
        chk("idle_rdata", mem_rdata, 32'h0);

        // Read slave 1 with 5 busy cycles; address moves to slave 0 meanwhile
        tick();
        s_rbusy  = 4'b0010;
        mem_addr = 32'h0001_0004; mem_rstrb = 1'b1;
        mid();
        chk("rd1_s_rd", 32'(s_rd), 32'h2);
        busy_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            mem_rstrb = 1'b0;
            mem_addr  = 32'h0000_0010;
            mid();
            if (mem_rbusy === 1'b1) busy_cnt++;
        end
        chk("rd1_busy_cycles", 32'(busy_cnt), 32'd5);
        tick();
        s_rbusy = 4'b0000;
        mid();
        chk("rd1_rbusy_end", 32'(mem_rbusy), 32'h0);
        chk("rd1_rdata",     mem_rdata, 32'hCAFE_F00D);
        chk("rd1_s_rd_none", 32'(s_rd), 32'h0);

        // Write slave 2 with coincident read strobe, one wbusy cycle
        tick();
        s_wbusy  = 4'b0100;
        mem_addr = 32'h0040_0000; mem_wmask = 4'h1; mem_rstrb = 1'b1;
        mid();
        chk("wr2_s_wr", 32'(s_wr), 32'h4);
        chk("wr2_s_rd", 32'(s_rd), 32'h0);
        tick();
        mem_wmask = 4'h0; mem_rstrb = 1'b0;
        mid();
        chk("wr2_wbusy",    32'(mem_wbusy), 32'h1);
        chk("wr2_rbusy",    32'(mem_rbusy), 32'h0);
        chk("wr2_s_wr_off", 32'(s_wr), 32'h0);
        tick();
        s_wbusy = 4'b0000;
        mid();
        chk("wr2_wbusy_end", 32'(mem_wbusy), 32'h0);

        // Unmapped read, second unmapped write, clear
        tick();
        mem_addr = 32'h0080_0000; mem_rstrb = 1'b1;
        mid();
        chk("bad_s_rd", 32'(s_rd), 32'h0);
        tick();
        mem_rstrb = 1'b0;
        mid();
        chk("bad_rdata",    mem_rdata, 32'h0);
        chk("bad_rbusy",    32'(mem_rbusy), 32'h0);
        chk("bad_err_flag", 32'(err_flag), 32'h1);
        chk("bad_err_addr", err_addr, 32'h0080_0000);
        tick();
        mem_addr = 32'h0090_0000; mem_wmask = 4'hF;
        mid();
        chk("bad2_s_wr", 32'(s_wr), 32'h0);
        tick();
        mem_wmask = 4'h0;
        mid();
        chk("bad2_err_addr_kept", err_addr, 32'h0080_0000);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        mid();
        chk("clr_err_flag", 32'(err_flag), 32'h0);
        chk("clr_err_addr", err_addr, 32'h0);

        // Error set together with clear keeps the flag and takes the new address
        tick();
        mem_addr = 32'h0080_0000; mem_rstrb = 1'b1;
        tick();
        mem_addr = 32'h00B0_0000; err_clr = 1'b1;
        tick();
        mem_rstrb = 1'b0; err_clr = 1'b0;
        mid();
        chk("setclr_err_flag", 32'(err_flag), 32'h1);
        chk("setclr_err_addr", err_addr, 32'h00B0_0000);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        mid();
        chk("setclr_cleared", 32'(err_flag), 32'h0);

        // Slave 3 stuck busy: watchdog aborts after 8 busy cycles if enabled
        tick();
        s_rbusy  = 4'b1000;
        mem_addr = 32'h0042_0004; mem_rstrb = 1'b1;
        mid();
        chk("stuck_s_rd", 32'(s_rd), 32'h8);
        busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            mem_rstrb = 1'b0;
            mid();
            if (mem_rbusy === 1'b1) busy_cnt++;
        end
`ifdef FEMTO_BUS_TIMEOUT_EN
        exp_busy = 8;
        chk("stuck_err_flag", 32'(err_flag), 32'h1);
        chk("stuck_err_addr", err_addr, 32'h0042_0004);
        chk("stuck_rdata",    mem_rdata, 32'h0);
`else
        exp_busy = 12;
        chk("stuck_err_flag", 32'(err_flag), 32'h0);
        chk("stuck_rbusy",    32'(mem_rbusy), 32'h1);
`endif
        chk("stuck_busy_cycles", 32'(busy_cnt), 32'(exp_busy));
        tick();
        s_rbusy = 4'b0000;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Reset asserted in RD_WAIT with a new read strobe pending
        s_rbusy  = 4'b0010;
        mem_addr = 32'h0001_0000; mem_rstrb = 1'b1;
        tick();
        mem_rstrb = 1'b0;
        mid();
        chk("rstw_rbusy_before", 32'(mem_rbusy), 32'h1);
        mem_addr  = 32'h0000_0010; mem_rstrb = 1'b1;
        reset     = 1'b1;
        #1;
        chk("rstw_rbusy", 32'(mem_rbusy), 32'h0);
        chk("rstw_rdata", mem_rdata, 32'h0);
        chk("rstw_s_rd",  32'(s_rd), 32'h0);
        tick();
        reset   = 1'b0;
        s_rbusy = 4'b0000;
        mid();
        chk("post_rst_s_rd", 32'(s_rd), 32'h1);
        tick();
        mem_rstrb = 1'b0;
        mid();
        chk("post_rst_rdata", mem_rdata, 32'h1234_5678);
        chk("post_rst_rbusy", 32'(mem_rbusy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
